// File: rtl/hft_oq_pkg.sv
// Shared types for the order-quantity scheduler: channel id and tagged result word.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hft_oq_pkg;
   localparam int OQ_NUM_CH = 4;
   localparam int OQ_INV_W  = 64;
   localparam int OQ_QTY_W  = 64;
   localparam int OQ_CH_W   = $clog2(OQ_NUM_CH);

   typedef logic [OQ_CH_W-1:0] ch_t;

   typedef struct packed {
      ch_t                   ch;
      logic [OQ_QTY_W-1:0]   qty;
   } res_t;
endpackage

// File: rtl/oq_result_fifo.sv
// First-word-fall-through FIFO of channel-tagged results with occupancy count.
// Latency: a push is visible at o_head on the cycle after the write edge.
// Backpressure: none here; the caller's credit scheme keeps pushes off a full FIFO.
module oq_result_fifo
   import hft_oq_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     i_clk,
   input  logic                     i_reset_n,
   input  logic                     i_push,
   input  res_t                     i_push_dat,
   input  logic                     i_pop,
   output res_t                     o_head,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_V = DEPTH[AW:0];
   localparam logic [AW:0] PTR_ONE = 1;

   res_t        mem [DEPTH];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic        full;
   logic        do_push;
   logic        do_pop;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign o_count = wr_ptr - rd_ptr;
   assign o_empty = (o_count == '0);
   assign full    = (o_count == DEPTH_V);
   assign do_pop  = i_pop && !o_empty;
   assign do_push = i_push && (!full || do_pop);
   assign o_head  = mem[rd_ptr[AW-1:0]];

   // Read/write pointer advance; reset empties the queue.
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   // Storage array; contents are don't-care while the slot is unoccupied.
   always_ff @(posedge i_clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= i_push_dat;
   end

   // A push onto a full FIFO without a same-cycle pop means the credit count is broken.
   a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_reset_n)
      !(i_push && full && !i_pop));
endmodule

// File: rtl/order_quantity_scheduler.sv
// Shares one fixed-latency order-quantity datapath among channels, round-robin, latest-wins.
// Latency: update sampled at E0 issues after E1; result visible after E0+DP_LATENCY+2.
// Backpressure: issue stalls while FIFO occupancy plus in-flight tags would reach FIFO_DEPTH.
module order_quantity_scheduler
   import hft_oq_pkg::*;
#(
   parameter int NUM_CH     = OQ_NUM_CH,
   parameter int DP_LATENCY = 2,
   parameter int FIFO_DEPTH = 4,
   parameter int INV_W      = OQ_INV_W,
   parameter int QTY_W      = OQ_QTY_W
) (
   input  logic                      i_clk,
   input  logic                      i_reset_n,
   input  logic [NUM_CH-1:0]         i_inv_valid,
   input  logic [NUM_CH*INV_W-1:0]   i_inv_data,
   output logic                      o_dp_valid,
   output logic [INV_W-1:0]          o_dp_inventory,
   input  logic [QTY_W-1:0]          i_dp_order,
   output logic                      o_res_valid,
   output logic [$clog2(NUM_CH)-1:0] o_res_ch,
   output logic [QTY_W-1:0]          o_res_qty,
   input  logic                      i_res_ready,
   output logic [15:0]               o_coalesce_cnt
);
   localparam int CH_W = $clog2(NUM_CH);
   localparam int FC_W = $clog2(FIFO_DEPTH) + 1;
   localparam int CR_W = $clog2(FIFO_DEPTH + DP_LATENCY + 2) + 1;
   localparam int OV_W = $clog2(NUM_CH) + 1;

   logic [NUM_CH-1:0]     pend;
   logic [INV_W-1:0]      pend_data [NUM_CH];
   logic [CH_W-1:0]       rr_ptr;
   logic [CH_W-1:0]       dp_ch;
   logic [DP_LATENCY-1:0] tag_vld;
   logic [CH_W-1:0]       tag_ch [DP_LATENCY];

   logic                  gnt_vld;
   logic [CH_W-1:0]       gnt_ch;
   logic [CH_W-1:0]       cand;
   logic [CR_W-1:0]       inflight;
   logic                  credit_ok;
   logic [OV_W-1:0]       n_ovw;
   logic [16:0]           coal_sum;

   res_t                  push_dat;
   res_t                  head;
   logic                  fifo_empty;
   logic [FC_W-1:0]       fifo_count;
   logic                  pop;

   // Everything between the issue register and the FIFO write holds a credit.
   always_comb begin
      inflight = CR_W'(o_dp_valid);
      for (int k = 0; k < DP_LATENCY; k++) begin
         inflight = inflight + CR_W'(tag_vld[k]);
      end
   end

   assign credit_ok = (CR_W'(fifo_count) + inflight) < CR_W'(FIFO_DEPTH);

   // Round-robin pick: first pending channel at or after rr_ptr, gated by credit.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_ch  = '0;
      cand    = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         cand = rr_ptr + CH_W'(i);
         if (!gnt_vld && pend[cand]) begin
            gnt_vld = 1'b1;
            gnt_ch  = cand;
         end
      end
      if (!credit_ok) gnt_vld = 1'b0;
   end

   // Count pending values overwritten this edge; a granted channel's value was consumed.
   always_comb begin
      n_ovw = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (i_inv_valid[c] && pend[c] && !(gnt_vld && gnt_ch == CH_W'(c))) begin
            n_ovw = n_ovw + OV_W'(1);
         end
      end
      coal_sum = {1'b0, o_coalesce_cnt} + 17'(n_ovw);
   end

   // Pending capture, issue register and round-robin pointer.
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         pend           <= '0;
         rr_ptr         <= '0;
         o_dp_valid     <= 1'b0;
         o_dp_inventory <= '0;
         dp_ch          <= '0;
         o_coalesce_cnt <= '0;
         for (int c = 0; c < NUM_CH; c++) pend_data[c] <= '0;
      end else begin
         o_dp_valid <= gnt_vld;
         if (gnt_vld) begin
            o_dp_inventory <= pend_data[gnt_ch];
            dp_ch          <= gnt_ch;
            rr_ptr         <= gnt_ch + CH_W'(1);
         end
         // A fresh update wins over the grant clear, so a same-edge update stays pending.
         for (int c = 0; c < NUM_CH; c++) begin
            if (i_inv_valid[c]) begin
               pend_data[c] <= i_inv_data[c*INV_W +: INV_W];
               pend[c]      <= 1'b1;
            end else if (gnt_vld && gnt_ch == CH_W'(c)) begin
               pend[c]      <= 1'b0;
            end
         end
         o_coalesce_cnt <= coal_sum[16] ? 16'hFFFF : coal_sum[15:0];
      end
   end

   // Tag pipe behind the issue register; its tail lines up with the datapath result.
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         tag_vld <= '0;
         for (int k = 0; k < DP_LATENCY; k++) tag_ch[k] <= '0;
      end else begin
         tag_vld[0] <= o_dp_valid;
         tag_ch[0]  <= dp_ch;
         for (int k = 1; k < DP_LATENCY; k++) begin
            tag_vld[k] <= tag_vld[k-1];
            tag_ch[k]  <= tag_ch[k-1];
         end
      end
   end

   assign push_dat = '{ch: tag_ch[DP_LATENCY-1], qty: i_dp_order};
   assign pop      = o_res_valid && i_res_ready;

   oq_result_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_res_fifo (
      .i_clk      (i_clk),
      .i_reset_n  (i_reset_n),
      .i_push     (tag_vld[DP_LATENCY-1]),
      .i_push_dat (push_dat),
      .i_pop      (pop),
      .o_head     (head),
      .o_empty    (fifo_empty),
      .o_count    (fifo_count)
   );

   // Head fields read as zero while the FIFO is empty.
   assign o_res_valid = !fifo_empty;
   assign o_res_ch    = o_res_valid ? head.ch  : '0;
   assign o_res_qty   = o_res_valid ? head.qty : '0;
endmodule

// File: tb/tb_order_quantity_scheduler.sv
// Bench for order_quantity_scheduler: queue-based reference model plus directed scenarios.
// Latency: datapath stub returns inventory+1 DP_LATENCY cycles after the issue strobe.
// Backpressure: scenarios drive i_res_ready low to exercise credit-limited issue.
module tb_order_quantity_scheduler;
   localparam int NCH   = 4;
   localparam int L     = 2;
   localparam int DEPTH = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NCH-1:0]    inv_valid;
   logic [NCH*64-1:0] inv_data;
   logic              dp_valid;
   logic [63:0]       dp_inv;
   logic [63:0]       dp_order;
   logic              res_valid;
   logic [1:0]        res_ch;
   logic [63:0]       res_qty;
   logic              res_ready;
   logic [15:0]       coal;

   always #5 clk = ~clk;

   order_quantity_scheduler dut (
      .i_clk          (clk),
      .i_reset_n      (rst_n),
      .i_inv_valid    (inv_valid),
      .i_inv_data     (inv_data),
      .o_dp_valid     (dp_valid),
      .o_dp_inventory (dp_inv),
      .i_dp_order     (dp_order),
      .o_res_valid    (res_valid),
      .o_res_ch       (res_ch),
      .o_res_qty      (res_qty),
      .i_res_ready    (res_ready),
      .o_coalesce_cnt (coal)
   );

   // Datapath stub: result = issued inventory + 1, DP_LATENCY cycles after the strobe.
   logic [63:0] stub [L];
   always @(posedge clk) begin
      stub[0] <= dp_inv + 64'd1;
      for (int k = 1; k < L; k++) stub[k] <= stub[k-1];
   end
   assign dp_order = stub[L-1];

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // ---------------- reference model ----------------
   typedef struct { int ch; logic [63:0] qty; int cyc; } fl_t;
   typedef struct { int ch; logic [63:0] qty; } rs_t;
   fl_t         flight[$];
   rs_t         mq[$];
   bit          m_pend [NCH];
   logic [63:0] m_val  [NCH];
   int          m_rr, m_coal, cyc, g, occ, cm;
   bit          m_dpv, m_pop;
   logic [63:0] m_dpi;

   always @(posedge clk) begin
      if (!rst_n) begin
         flight.delete();
         mq.delete();
         for (int c = 0; c < NCH; c++) begin
            m_pend[c] = 1'b0;
            m_val[c]  = '0;
         end
         m_rr = 0; m_coal = 0; m_dpv = 1'b0; m_dpi = '0;
      end else begin
         occ   = mq.size() + flight.size();
         m_pop = (mq.size() > 0) && res_ready;
         g = -1;
         if (occ < DEPTH) begin
            for (int i = 0; i < NCH; i++) begin
               cm = (m_rr + i) % NCH;
               if (g < 0 && m_pend[cm]) g = cm;
            end
         end
         if (m_pop) void'(mq.pop_front());
         while (flight.size() > 0 && flight[0].cyc + L + 1 == cyc) begin
            mq.push_back('{ch: flight[0].ch, qty: flight[0].qty});
            void'(flight.pop_front());
         end
         if (g >= 0) begin
            m_dpv = 1'b1;
            m_dpi = m_val[g];
            flight.push_back('{ch: g, qty: m_val[g] + 64'd1, cyc: cyc});
            m_pend[g] = 1'b0;
            m_rr = (g + 1) % NCH;
         end else begin
            m_dpv = 1'b0;
         end
         for (int c = 0; c < NCH; c++) begin
            if (inv_valid[c]) begin
               if (m_pend[c] && m_coal < 16'hFFFF) m_coal++;
               m_val[c]  = inv_data[c*64 +: 64];
               m_pend[c] = 1'b1;
            end
         end
      end
      cyc++;
      #1;
      chk("dp_valid", 64'(dp_valid), 64'(m_dpv));
      chk("dp_inventory", dp_inv, m_dpi);
      chk("coalesce_cnt", 64'(coal), 64'(m_coal));
      chk("res_valid", 64'(res_valid), 64'(mq.size() > 0));
      if (mq.size() > 0) begin
         chk("res_ch", 64'(res_ch), 64'(mq[0].ch));
         chk("res_qty", res_qty, mq[0].qty);
      end
   end

   // ---------------- observation log ----------------
   logic [63:0] iss[$];
   int          rs_ch[$];
   logic [63:0] rs_qty[$];

   always @(negedge clk) begin
      #1;
      if (rst_n && dp_valid) iss.push_back(dp_inv);
      if (rst_n && res_valid && res_ready) begin
         rs_ch.push_back(int'(res_ch));
         rs_qty.push_back(res_qty);
      end
   end

   function automatic logic [63:0] iss_at(input int i);
      return (i < iss.size()) ? iss[i] : '1;
   endfunction
   function automatic logic [63:0] qty_at(input int i);
      return (i < rs_qty.size()) ? rs_qty[i] : '1;
   endfunction
   function automatic logic [63:0] ch_at(input int i);
      return (i < rs_ch.size()) ? 64'(rs_ch[i]) : '1;
   endfunction

   task automatic upd(input int c, input logic [63:0] v);
      inv_valid[c]          = 1'b1;
      inv_data[c*64 +: 64]  = v;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n     = 1'b0;
      inv_valid = '0;
      res_ready = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      iss.delete();
      rs_ch.delete();
      rs_qty.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; inv_valid = '0; inv_data = '0; res_ready = 1'b1;
      cyc = 0;

      // Reset state and single-update latency.
      do_reset();
      chk("rst_dp_valid", 64'(dp_valid), 64'd0);
      chk("rst_dp_inventory", dp_inv, 64'd0);
      chk("rst_res_valid", 64'(res_valid), 64'd0);
      chk("rst_coalesce", 64'(coal), 64'd0);
      upd(2, 64'h10);
      @(negedge clk);
      inv_valid = '0;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         if (k == 1) begin
            chk("t1_issue_valid", 64'(dp_valid), 64'd1);
            chk("t1_issue_value", dp_inv, 64'h10);
         end
         chk($sformatf("t1_res_valid_e%0d", k), 64'(res_valid), 64'(k == 4));
         if (k == 4) begin
            chk("t1_res_ch", 64'(res_ch), 64'd2);
            chk("t1_res_qty", res_qty, 64'h11);
         end
      end

      // All channels at once: consecutive issue in channel order.
      do_reset();
      for (int c = 0; c < NCH; c++) upd(c, 64'(c + 1));
      @(negedge clk);
      inv_valid = '0;
      repeat (12) @(negedge clk);
      chk("t2_issue_count", 64'(iss.size()), 64'd4);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("t2_issue%0d", i), iss_at(i), 64'(i + 1));
         chk($sformatf("t2_res_ch%0d", i), ch_at(i), 64'(i));
         chk($sformatf("t2_res_qty%0d", i), qty_at(i), 64'(i + 2));
      end
      chk("t2_coalesce", 64'(coal), 64'd0);

      // Repeated ch1 updates while ch0 holds the first grant.
      do_reset();
      upd(0, 64'hA); upd(1, 64'h5);
      @(negedge clk); inv_valid = '0;
      upd(0, 64'hB); upd(1, 64'h6);
      @(negedge clk); inv_valid = '0;
      upd(1, 64'h7);
      @(negedge clk); inv_valid = '0;
      repeat (12) @(negedge clk);
      chk("t3_issue_count", 64'(iss.size()), 64'd4);
      chk("t3_issue0", iss_at(0), 64'hA);
      chk("t3_issue1", iss_at(1), 64'h6);
      chk("t3_issue2", iss_at(2), 64'hB);
      chk("t3_issue3", iss_at(3), 64'h7);
      chk("t3_coalesce", 64'(coal), 64'd1);

      // Consumer stalled: credits cap issue at FIFO_DEPTH, then drain without loss.
      do_reset();
      res_ready = 1'b0;
      for (int k = 0; k < 15; k++) begin
         for (int c = 0; c < NCH; c++) upd(c, 64'(32'h1000 * (k + 1) + c));
         @(negedge clk);
      end
      inv_valid = '0;
      repeat (3) @(negedge clk);
      chk("t4_stalled_issues", 64'(iss.size()), 64'd4);
      chk("t4_coalesce", 64'(coal), 64'd52);
      res_ready = 1'b1;
      repeat (20) @(negedge clk);
      chk("t4_result_count", 64'(rs_qty.size()), 64'd8);
      chk("t4_res0_qty", qty_at(0), 64'h1001);
      chk("t4_res3_qty", qty_at(3), 64'h4004);
      chk("t4_res4_qty", qty_at(4), 64'hF001);
      chk("t4_res7_qty", qty_at(7), 64'hF004);

      // Reset right after an issue discards the in-flight result.
      do_reset();
      upd(1, 64'h55);
      @(negedge clk); inv_valid = '0;
      @(negedge clk);
      chk("t5_issued", 64'(dp_valid), 64'd1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("t5_dp_valid", 64'(dp_valid), 64'd0);
      chk("t5_dp_inventory", dp_inv, 64'd0);
      chk("t5_res_valid", 64'(res_valid), 64'd0);
      chk("t5_res_ch", 64'(res_ch), 64'd0);
      chk("t5_res_qty", res_qty, 64'd0);
      chk("t5_coalesce", 64'(coal), 64'd0);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      chk("t5_no_stale_result", 64'(rs_qty.size()), 64'd0);

      // Update landing on the same edge as its channel's grant.
      do_reset();
      upd(3, 64'h30);
      @(negedge clk); inv_valid = '0;
      upd(3, 64'h31);
      @(negedge clk); inv_valid = '0;
      repeat (8) @(negedge clk);
      chk("t6_issue_count", 64'(iss.size()), 64'd2);
      chk("t6_issue0", iss_at(0), 64'h30);
      chk("t6_issue1", iss_at(1), 64'h31);
      chk("t6_coalesce", 64'(coal), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
